multi_level_parking_ctrl: RTL and testbench

MULTI_LEVEL_PARKING_CTRL -- requirements
Module: multi_level_parking_ctrl

---
 rtl/multi_level_parking_ctrl.sv | 144 ++++++++++++++
 tb/tb_multi_level_parking_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multi_level_parking_ctrl.sv
// Password-gated entry controller for a multi-level car park: admits cars up to
// CAPACITY, tracks occupancy from exit-gate edges and locks out repeated bad passwords.
module multi_level_parking_ctrl #(
   parameter int                  CAPACITY    = 8,
   parameter int                  PW_WIDTH    = 4,
   parameter logic [PW_WIDTH-1:0] PASSCODE    = 4'b1011,
   parameter int                  MAX_TRIES   = 3,
   parameter int                  WAIT_CYCLES = 16,
   parameter int                  LOCK_CYCLES = 32
) (
   input  logic                             CLOCK,
   input  logic                             RESET,
   input  logic                             Entrance,
   input  logic                             Exit,
   input  logic [PW_WIDTH-1:0]              PASSWORD,
   input  logic                             PASS_VALID,
   output logic                             Green,
   output logic                             Red,
   output logic [$clog2(CAPACITY+1)-1:0]    Count_CAR,
   output logic [2:0]                       INDICATOR,
   output logic                             Full,
   output logic                             Alarm
);

   localparam int CW   = $clog2(CAPACITY + 1);
   localparam int TRW  = $clog2(MAX_TRIES + 1);
   localparam int TMAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [CW-1:0]  CAP_C     = CW'(CAPACITY);
   localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
   localparam logic [TW-1:0]  WAIT_LAST = TW'(WAIT_CYCLES - 1);
   localparam logic [TW-1:0]  LOCK_LAST = TW'(LOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE          = 3'b000,
      WAIT_PASSWORD = 3'b001,
      WRONG_PASS    = 3'b010,
      RIGHT_PASS    = 3'b011,
      LOCKOUT       = 3'b100
   } state_t;

   state_t         state, state_next;
   logic [TRW-1:0] tries, tries_next;
   logic [TW-1:0]  timer, timer_next;
   logic [CW-1:0]  count_next;
   logic           exit_q;
   logic           exit_edge;
   logic           admit;

   assign exit_edge = Exit && !exit_q;
   assign INDICATOR = state;

   // Next-state, timer and retry bookkeeping; admit flags the single cycle a car is accepted.
   always_comb begin
      state_next = state;
      tries_next = tries;
      timer_next = timer;
      admit      = 1'b0;
      case (state)
         IDLE: begin
            if (Entrance && (Count_CAR < CAP_C)) begin
               state_next = WAIT_PASSWORD;
               timer_next = '0;
            end
         end
         WAIT_PASSWORD: begin
            if (PASS_VALID) begin
               if (PASSWORD == PASSCODE) begin
                  state_next = RIGHT_PASS;
                  tries_next = '0;
                  admit      = 1'b1;
               end else begin
                  state_next = WRONG_PASS;
                  tries_next = (tries == TRIES_MAX) ? tries : tries + 1'b1;
               end
            end else if (timer == WAIT_LAST) begin
               state_next = IDLE;
               tries_next = '0;
               timer_next = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         WRONG_PASS: begin
            timer_next = '0;
            state_next = (tries == TRIES_MAX) ? LOCKOUT : WAIT_PASSWORD;
         end
         LOCKOUT: begin
            if (timer == LOCK_LAST) begin
               state_next = IDLE;
               tries_next = '0;
               timer_next = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         RIGHT_PASS: begin
            if (!Entrance) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            tries_next = '0;
            timer_next = '0;
         end
      endcase
   end

   // A simultaneous admission and exit edge cancel out; the count saturates at both ends.
   always_comb begin
      count_next = Count_CAR;
      if (admit && !exit_edge && (Count_CAR != CAP_C))
         count_next = Count_CAR + 1'b1;
      else if (exit_edge && !admit && (Count_CAR != '0))
         count_next = Count_CAR - 1'b1;
   end

   // Moore outputs are registered from the next state so they align with INDICATOR.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state     <= IDLE;
         tries     <= '0;
         timer     <= '0;
         Count_CAR <= '0;
         exit_q    <= 1'b0;
         Green     <= 1'b0;
         Red       <= 1'b0;
         Full      <= 1'b0;
         Alarm     <= 1'b0;
      end else begin
         state     <= state_next;
         tries     <= tries_next;
         timer     <= timer_next;
         Count_CAR <= count_next;
         exit_q    <= Exit;
         Green     <= (state_next == RIGHT_PASS);
         Red       <= (state_next == WRONG_PASS) || (state_next == LOCKOUT) ||
                      ((state_next == IDLE) && (count_next == CAP_C));
         Full      <= (count_next == CAP_C);
         Alarm     <= (state_next == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_multi_level_parking_ctrl.sv
// Directed bench for multi_level_parking_ctrl: expected output snapshots are queued
// with each stimulus step and checked one clock later.
module tb_multi_level_parking_ctrl;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       Entrance;
   logic       Exit;
   logic [3:0] PASSWORD;
   logic       PASS_VALID;
   logic       Green, Red, Full, Alarm;
   logic [3:0] Count_CAR;
   logic [2:0] INDICATOR;

   typedef struct {
      string      tag;
      logic [2:0] ind;
      logic [3:0] cnt;
      logic       g, r, f, a;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [2:0] S_IDLE = 3'b000, S_WAIT = 3'b001, S_WRONG = 3'b010,
                          S_RIGHT = 3'b011, S_LOCK = 3'b100;

   multi_level_parking_ctrl dut (
      .CLOCK(CLOCK), .RESET(RESET), .Entrance(Entrance), .Exit(Exit),
      .PASSWORD(PASSWORD), .PASS_VALID(PASS_VALID), .Green(Green), .Red(Red),
      .Count_CAR(Count_CAR), .INDICATOR(INDICATOR), .Full(Full), .Alarm(Alarm)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic apply_stimulus(input logic rst, input logic ent, input logic ext,
                                 input logic pv, input logic [3:0] pw);
      RESET      = rst;
      Entrance   = ent;
      Exit       = ext;
      PASS_VALID = pv;
      PASSWORD   = pw;
   endtask

   task automatic check_output();
      exp_t e;
      @(posedge CLOCK);
      #1;
      e = exp_q.pop_front();
      checks += 6;
      assert (INDICATOR === e.ind) else begin
         errors++; $error("FAIL %s.INDICATOR observed=%b expected=%b", e.tag, INDICATOR, e.ind);
      end
      assert (Count_CAR === e.cnt) else begin
         errors++; $error("FAIL %s.Count_CAR observed=%0d expected=%0d", e.tag, Count_CAR, e.cnt);
      end
      assert (Green === e.g) else begin
         errors++; $error("FAIL %s.Green observed=%b expected=%b", e.tag, Green, e.g);
      end
      assert (Red === e.r) else begin
         errors++; $error("FAIL %s.Red observed=%b expected=%b", e.tag, Red, e.r);
      end
      assert (Full === e.f) else begin
         errors++; $error("FAIL %s.Full observed=%b expected=%b", e.tag, Full, e.f);
      end
      assert (Alarm === e.a) else begin
         errors++; $error("FAIL %s.Alarm observed=%b expected=%b", e.tag, Alarm, e.a);
      end
   endtask

   task automatic tick(input string tag, input logic [2:0] ind, input logic [3:0] cnt,
                       input logic g, input logic r, input logic f, input logic a);
      exp_t e;
      e.tag = tag; e.ind = ind; e.cnt = cnt; e.g = g; e.r = r; e.f = f; e.a = a;
      exp_q.push_back(e);
      check_output();
   endtask

   initial begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("reset0", S_IDLE, 4'd0, 0, 0, 0, 0);
      tick("reset1", S_IDLE, 4'd0, 0, 0, 0, 0);

      // Exit edge with an empty car park must not underflow.
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      tick("exit_empty", S_IDLE, 4'd0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("idle", S_IDLE, 4'd0, 0, 0, 0, 0);

      // Correct password admits one car.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("enter_wait", S_WAIT, 4'd0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1011);
      tick("right_pass", S_RIGHT, 4'd1, 1, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("right_hold", S_RIGHT, 4'd1, 1, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("right_leave", S_IDLE, 4'd1, 0, 0, 0, 0);

      // Password timeout: 16 cycles in WAIT_PASSWORD, then back to IDLE.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("to_enter", S_WAIT, 4'd1, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 15; i++) tick("to_wait", S_WAIT, 4'd1, 0, 0, 0, 0);
      tick("to_expire", S_IDLE, 4'd1, 0, 0, 0, 0);

      // Three wrong passwords lead to a 32-cycle lockout that ignores a correct code.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("lk_enter", S_WAIT, 4'd1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
         tick("lk_wrong", S_WRONG, 4'd1, 0, 1, 0, 0);
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
         if (k < 2) tick("lk_retry", S_WAIT, 4'd1, 0, 0, 0, 0);
      end
      tick("lk_start", S_LOCK, 4'd1, 0, 1, 0, 1);
      for (int i = 0; i < 31; i++) begin
         if (i == 10) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
         else         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
         tick("lk_hold", S_LOCK, 4'd1, 0, 1, 0, 1);
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("lk_release", S_IDLE, 4'd1, 0, 0, 0, 0);

      // Exit edge in the admission cycle leaves the count unchanged.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("sim_enter", S_WAIT, 4'd1, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
      tick("sim_admit_exit", S_RIGHT, 4'd1, 1, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("sim_leave", S_IDLE, 4'd1, 0, 0, 0, 0);

      // Fill to capacity.
      for (int k = 2; k <= 8; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
         tick("fill_wait", S_WAIT, 4'(k - 1), 0, 0, 0, 0);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1011);
         tick("fill_admit", S_RIGHT, 4'(k), 1, 0, (k == 8), 0);
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
         tick("fill_idle", S_IDLE, 4'(k), 0, (k == 8), (k == 8), 0);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("full_refuse", S_IDLE, 4'd8, 0, 1, 1, 0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      tick("full_exit", S_IDLE, 4'd7, 0, 0, 0, 0);
      tick("exit_held", S_IDLE, 4'd7, 0, 0, 0, 0);
      for (int k = 6; k >= 4; k--) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
         tick("drain_low", S_IDLE, 4'(k + 1), 0, 0, 0, 0);
         apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
         tick("drain_edge", S_IDLE, 4'(k), 0, 0, 0, 0);
      end

      // Reset while a car sits in RIGHT_PASS with five cars counted.
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick("rst_wait", S_WAIT, 4'd4, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1011);
      tick("rst_right", S_RIGHT, 4'd5, 1, 0, 0, 0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
      tick("rst_apply", S_IDLE, 4'd0, 0, 0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick("rst_after", S_IDLE, 4'd0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
